// File: rtl/adder_sum_accum_if.sv
// Handshake bundle between the adder stage, the frame accumulator and its consumer.
// The master side drives samples and the output ready; the slave side is the accumulator.
interface adder_sum_accum_if #(
  parameter int unsigned OUT_W = 8
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic signed [4:0]       in_sum;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_acc;
  logic                    out_sat;

  modport master (
    output in_valid,
    output in_sum,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_acc,
    input  out_sat
  );

  modport slave (
    input  in_valid,
    input  in_sum,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_acc,
    output out_sat
  );
endinterface

// File: rtl/adder_sum_accum.sv
// Accumulates frames of N_SAMPLES signed 5-bit sums into a saturating OUT_W-bit total and
// hands each frame total out on a valid/ready port with a sticky saturation flag.
module adder_sum_accum #(
  parameter int unsigned N_SAMPLES = 4,
  parameter int unsigned OUT_W     = 8
) (
  input logic               clk,
  input logic               rst_n,
  adder_sum_accum_if.slave  bus_io
);

  localparam int unsigned CntW    = $clog2(N_SAMPLES);
  localparam int          AccMaxI = int'((32'd1 << (OUT_W - 1)) - 32'd1);
  localparam int          AccMinI = -AccMaxI - 1;

  localparam logic signed [OUT_W:0] AccMax  = (OUT_W + 1)'(AccMaxI);
  localparam logic signed [OUT_W:0] AccMin  = (OUT_W + 1)'(AccMinI);
  localparam logic [CntW-1:0]       LastCnt = CntW'(N_SAMPLES - 1);

  typedef enum logic {StAccum, StHold} state_e;

  state_e                  state_q, state_d;
  logic signed [OUT_W-1:0] acc_q, acc_d;
  logic signed [OUT_W-1:0] out_acc_q, out_acc_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    sat_q, sat_d;
  logic                    out_sat_q, out_sat_d;

  logic signed [OUT_W:0]   in_ext;
  logic signed [OUT_W:0]   sum_ext;
  logic signed [OUT_W-1:0] acc_clamp;
  logic                    clamped;

  // One extra bit of headroom means the raw sum can never wrap before clamping.
  always_comb begin
    in_ext    = $signed({{(OUT_W - 4){bus_io.in_sum[4]}}, bus_io.in_sum});
    sum_ext   = $signed({acc_q[OUT_W-1], acc_q}) + in_ext;
    acc_clamp = sum_ext[OUT_W-1:0];
    clamped   = 1'b0;
    if (sum_ext > AccMax) begin
      acc_clamp = AccMax[OUT_W-1:0];
      clamped   = 1'b1;
    end else if (sum_ext < AccMin) begin
      acc_clamp = AccMin[OUT_W-1:0];
      clamped   = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    out_acc_d = out_acc_q;
    out_sat_d = out_sat_q;
    unique case (state_q)
      StAccum: begin
        if (bus_io.in_valid) begin
          acc_d = acc_clamp;
          sat_d = sat_q | clamped;
          if (cnt_q == LastCnt) begin
            state_d   = StHold;
            out_acc_d = acc_clamp;
            out_sat_d = sat_q | clamped;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StHold: begin
        // Inputs are ignored here; in_ready is low so upstream keeps its sample.
        if (bus_io.out_ready) begin
          state_d = StAccum;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StAccum;
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      out_acc_q <= '0;
      out_sat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      out_acc_q <= out_acc_d;
      out_sat_q <= out_sat_d;
    end
  end

  assign bus_io.in_ready  = (state_q == StAccum);
  assign bus_io.out_valid = (state_q == StHold);
  assign bus_io.out_acc   = out_acc_q;
  assign bus_io.out_sat   = out_sat_q;

endmodule

// File: tb/tb_adder_sum_accum.sv
// Drives two accumulators (OUT_W=8 and OUT_W=6) in lockstep from one stimulus stream and
// scores every frame total against an integer model queued at accept time.
module tb_adder_sum_accum;

  localparam int N = 4;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic signed [4:0] in_sum;
  logic              out_ready;

  adder_sum_accum_if #(.OUT_W(8)) bus8 ();
  adder_sum_accum_if #(.OUT_W(6)) bus6 ();

  assign bus8.in_valid  = in_valid;
  assign bus8.in_sum    = in_sum;
  assign bus8.out_ready = out_ready;
  assign bus6.in_valid  = in_valid;
  assign bus6.in_sum    = in_sum;
  assign bus6.out_ready = out_ready;

  adder_sum_accum #(.N_SAMPLES(N), .OUT_W(8)) u_dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus8.slave)
  );

  adder_sum_accum #(.N_SAMPLES(N), .OUT_W(6)) u_dut6 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus6.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int acc8;
    int sat8;
    int acc6;
    int sat6;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int m_hold = 0;
  int m_cnt  = 0;
  int m_acc8 = 0;
  int m_sat8 = 0;
  int m_acc6 = 0;
  int m_sat6 = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void step(inout int acc, inout int sat, input int s, input int w);
    int t;
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    t  = acc + s;
    if (t > hi) begin
      t   = hi;
      sat = 1;
    end else if (t < lo) begin
      t   = lo;
      sat = 1;
    end
    acc = t;
  endfunction

  // Reference model and scoreboard; advanced on the falling edge to predict the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      m_hold = 0;
      m_cnt  = 0;
      m_acc8 = 0;
      m_sat8 = 0;
      m_acc6 = 0;
      m_sat6 = 0;
      q.delete();
    end else begin
      check("in_ready8", int'(bus8.in_ready), int'(m_hold == 0));
      check("in_ready6", int'(bus6.in_ready), int'(m_hold == 0));
      check("out_valid8", int'(bus8.out_valid), m_hold);
      check("out_valid6", int'(bus6.out_valid), m_hold);
      if (m_hold != 0) begin
        if (q.size() == 0) begin
          check("queue_empty_in_hold", q.size(), 1);
        end else begin
          e = q[0];
          check("out_acc8", int'(bus8.out_acc), e.acc8);
          check("out_sat8", int'(bus8.out_sat), e.sat8);
          check("out_acc6", int'(bus6.out_acc), e.acc6);
          check("out_sat6", int'(bus6.out_sat), e.sat6);
          if (out_ready) begin
            void'(q.pop_front());
            m_hold = 0;
            m_cnt  = 0;
            m_acc8 = 0;
            m_sat8 = 0;
            m_acc6 = 0;
            m_sat6 = 0;
          end
        end
      end else if (in_valid) begin
        step(m_acc8, m_sat8, int'(in_sum), 8);
        step(m_acc6, m_sat6, int'(in_sum), 6);
        if (m_cnt == N - 1) begin
          e.acc8 = m_acc8;
          e.sat8 = m_sat8;
          e.acc6 = m_acc6;
          e.sat6 = m_sat6;
          q.push_back(e);
          m_hold = 1;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  task automatic send(input int s);
    int accepted;
    accepted = 0;
    in_valid = 1'b1;
    in_sum   = 5'(s);
    for (int k = 0; k < 50 && accepted == 0; k++) begin
      @(negedge clk);
      if (bus8.in_ready) accepted = 1;
    end
    check("send_accepted", accepted, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int a, input int b, input int c, input int d);
    send(a);
    send(b);
    send(c);
    send(d);
  endtask

  task automatic wait_idle();
    int drained;
    drained = 0;
    for (int k = 0; k < 100 && drained == 0; k++) begin
      @(negedge clk);
      if (q.size() == 0) drained = 1;
    end
    check("frame_drained", drained, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, int'(bus8.out_valid), 0);
    check({tag, "_in_ready"}, int'(bus8.in_ready), 1);
    check({tag, "_out_acc8"}, int'(bus8.out_acc), 0);
    check({tag, "_out_sat8"}, int'(bus8.out_sat), 0);
    check({tag, "_out_acc6"}, int'(bus6.out_acc), 0);
    check({tag, "_out_sat6"}, int'(bus6.out_sat), 0);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    int vals[7] = '{9, -3, 4, -12, 6, 11, 13};
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    out_ready = 1'b1;
    #2;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Defaults: -3, no saturation
    send_frame(3, -5, 15, -16);
    wait_idle();

    // Positive rail on the narrow instance
    send_frame(15, 15, 15, 1);
    wait_idle();

    // Negative rail, recovery from rail, then sat must clear
    send_frame(-16, -16, -16, -16);
    send_frame(15, 15, 15, -16);
    send_frame(1, 1, 1, 1);
    wait_idle();

    // Backpressure with ignored 7s pushed while in HOLD
    out_ready = 1'b0;
    send_frame(2, 2, 2, 2);
    in_valid = 1'b1;
    in_sum   = 5'sd7;
    repeat (6) @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    send_frame(1, -1, 5, 6);
    wait_idle();

    // Bubbles: only beats with in_valid high count
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i][0];
      in_sum   = 5'(vals[i]);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_idle();

    // Reset after two accepted samples
    send(5);
    send(6);
    async_reset("rst_mid_frame");
    send_frame(1, 2, 3, 4);
    wait_idle();

    // Reset while a frame is pending in HOLD
    out_ready = 1'b0;
    send_frame(7, 7, 7, 7);
    repeat (2) @(posedge clk);
    #1;
    async_reset("rst_in_hold");
    out_ready = 1'b1;
    send_frame(1, 2, 3, 4);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
